// File: rtl/dot_product_stream.sv
// dot_product_stream
//   Streaming two-stage dot-product engine. Each accepted beat carries N
//   operand pairs; BEATS beats form one vector, and one result per vector is
//   presented on a valid/ready output.
//
//   Stage 1 registers the N lane products plus first/last flags.
//   Stage 2 reduces the lanes, accumulates, and loads the result on the
//   last beat of a vector.
//
//   Ports
//     clk, rst_n     rising-edge clock, asynchronous active-low reset
//     flush          synchronous abort of the partial vector
//     in_valid/ready beat handshake; inp1/inp2 lane i at [(i+1)*DW-1:i*DW]
//     out_valid/ready result handshake; outp is the result (OW bits)
//     beat_idx       beats accepted so far in the current vector
//     sat_flag       only with DOT_PRODUCT_STREAM_SAT_EN: result was clamped
//
//   Build option: define DOT_PRODUCT_STREAM_SAT_EN to saturate the AW->OW
//   reduction instead of keeping the low OW bits.

module dps_lane #(
    parameter int DW     = 8,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] prod
);
    logic [2*DW-1:0] p;

    // Operands are extended to 2*DW first so the low 2*DW bits of the
    // product are exact for both signed and unsigned operands.
    generate
        if (SIGNED != 0) begin : g_s
            assign p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
        end else begin : g_u
            assign p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  prod <= '0;
        else if (en) prod <= p;
    end
endmodule

module dot_product_stream #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int BEATS  = 4,
    parameter int SIGNED = 0,
    parameter int AW     = 2*DW + $clog2(N*BEATS),
    parameter int OW     = AW
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DW*N-1:0]             inp1,
    input  logic [DW*N-1:0]             inp2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OW-1:0]               outp,
    output logic [$clog2(BEATS):0]      beat_idx
`ifdef DOT_PRODUCT_STREAM_SAT_EN
    ,
    output logic                        sat_flag
`endif
);
    localparam int BW = $clog2(BEATS) + 1;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } p1_t;

    p1_t                     p1;
    logic [N-1:0][2*DW-1:0]  prod;
    logic [AW-1:0]           lane_sum;
    logic [AW-1:0]           acc;
    logic [AW-1:0]           acc_nxt;
    logic [OW-1:0]           red;
    logic                    stall;
    logic                    fire;
    logic                    adv;
    logic                    load;
    logic                    last_beat;

    // Only a last beat can block: it needs the output register to be free.
    assign stall     = p1.vld && p1.last && out_valid && !out_ready;
    assign in_ready  = !stall && !flush;
    assign fire      = in_valid && in_ready;
    assign adv       = p1.vld && !stall && !flush;
    assign load      = adv && p1.last;
    assign last_beat = (beat_idx == BW'(BEATS - 1));

    // ---- stage 1: lane products ----
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            dps_lane #(.DW(DW), .SIGNED(SIGNED)) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (fire),
                .a     (inp1[gi*DW +: DW]),
                .b     (inp2[gi*DW +: DW]),
                .prod  (prod[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1       <= '0;
            beat_idx <= '0;
        end else if (flush) begin
            p1.vld   <= 1'b0;
            beat_idx <= '0;
        end else if (!stall) begin
            p1.vld <= in_valid;
            if (in_valid) begin
                p1.first <= (beat_idx == '0);
                p1.last  <= last_beat;
                beat_idx <= last_beat ? '0 : beat_idx + 1'b1;
            end
        end
    end

    // ---- stage 2: reduce and accumulate ----
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < N; i++) begin
            if (SIGNED != 0) lane_sum = lane_sum + AW'($signed(prod[i]));
            else             lane_sum = lane_sum + AW'(prod[i]);
        end
    end

    assign acc_nxt = (p1.first ? '0 : acc) + lane_sum;

`ifdef DOT_PRODUCT_STREAM_SAT_EN
    logic sat;
    generate
        if (OW < AW) begin : g_sat
            logic fits;
            if (SIGNED != 0) begin : g_s
                // Fits when every bit from OW-1 upward matches the sign bit.
                assign fits = (acc_nxt[AW-1:OW-1] == {(AW-OW+1){acc_nxt[AW-1]}});
                assign red  = fits ? acc_nxt[OW-1:0]
                            : (acc_nxt[AW-1] ? (OW'(1) << (OW-1))
                                             : ~(OW'(1) << (OW-1)));
            end else begin : g_u
                assign fits = ~|acc_nxt[AW-1:OW];
                assign red  = fits ? acc_nxt[OW-1:0] : '1;
            end
            assign sat = ~fits;
        end else begin : g_nosat
            assign red = acc_nxt[OW-1:0];
            assign sat = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    sat_flag <= 1'b0;
        else if (load) sat_flag <= sat;
    end
`else
    assign red = acc_nxt[OW-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
            outp      <= '0;
        end else begin
            if (flush)    acc <= '0;
            else if (adv) acc <= acc_nxt;

            // A new result takes priority so back-to-back vectors keep
            // out_valid high across the handoff.
            if (load) begin
                out_valid <= 1'b1;
                outp      <= red;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dot_product_stream.sv
// Scoreboard bench for dot_product_stream. Three instances share operand
// buses: u0 unsigned default, u1 signed, u2 unsigned with OW=16. Expected
// results are queued when a vector is issued; a negedge monitor pops and
// compares every delivered result.
module tb_dot_product_stream;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inp1, inp2;
    logic [2:0]  vin, rdy, ov, ordy, fl;
    logic [19:0] o0, o1;
    logic [15:0] o2;
    logic [2:0]  b0, b1, b2;
    logic        s0, s1, s2;

    logic [31:0] q0[$], q1[$], q2[$];
    int passed = 0, total = 0, waits = 0;

    always #5 clk = ~clk;

`ifdef DOT_PRODUCT_STREAM_SAT_EN
    `define DPS_SAT(s) , .sat_flag(s)
`else
    `define DPS_SAT(s)
    assign s0 = 1'b0;
    assign s1 = 1'b0;
    assign s2 = 1'b0;
`endif

    dot_product_stream u0 (
        .clk(clk), .rst_n(rst_n), .flush(fl[0]), .in_valid(vin[0]), .in_ready(rdy[0]),
        .inp1(inp1), .inp2(inp2), .out_valid(ov[0]), .out_ready(ordy[0]),
        .outp(o0), .beat_idx(b0) `DPS_SAT(s0));

    dot_product_stream #(.SIGNED(1)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(fl[1]), .in_valid(vin[1]), .in_ready(rdy[1]),
        .inp1(inp1), .inp2(inp2), .out_valid(ov[1]), .out_ready(ordy[1]),
        .outp(o1), .beat_idx(b1) `DPS_SAT(s1));

    dot_product_stream #(.OW(16)) u2 (
        .clk(clk), .rst_n(rst_n), .flush(fl[2]), .in_valid(vin[2]), .in_ready(rdy[2]),
        .inp1(inp1), .inp2(inp2), .out_valid(ov[2]), .out_ready(ordy[2]),
        .outp(o2), .beat_idx(b2) `DPS_SAT(s2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: result word is {sat_flag, outp zero-extended}.
    task automatic mon(input int k, input logic [31:0] act);
        logic [31:0] e = '0;
        bit got = 0;
        if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
        if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
        if (k == 2 && q2.size() > 0) begin e = q2.pop_front(); got = 1; end
        if (!got) begin
            total++;
            $display("FAIL out%0d: unexpected result 0x%0h", k, act);
        end else begin
            chk($sformatf("out%0d", k), act, e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ov[0] && ordy[0]) mon(0, {s0, 31'(o0)});
        if (rst_n && ov[1] && ordy[1]) mon(1, {s1, 31'(o1)});
        if (rst_n && ov[2] && ordy[2]) mon(2, {s2, 31'(o2)});
    end

    // One beat on instance k, all lanes a*b; returns 1ns after the accepting edge.
    task automatic beat(input int k, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        inp1 = {4{a}};
        inp2 = {4{b}};
        vin[k] = 1'b1;
        while (!rdy[k] && n < 50) begin @(posedge clk); #1; n++; end
        if (!rdy[k]) begin total++; $display("FAIL beat%0d: in_ready stuck low", k); end
        waits += n;
        @(posedge clk); #1;
        vin[k] = 1'b0;
    endtask

    task automatic vec(input int k, input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 4; i++) beat(k, a, b);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            total++;
            $display("FAIL drain: %0d results outstanding", q0.size() + q1.size() + q2.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; vin = '0; ordy = '1; fl = '0; inp1 = '0; inp2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {29'b0, ov}, 32'd0);
        chk("rst_outp0", {12'b0, o0}, 32'd0);
        chk("rst_beat_idx0", {29'b0, b0}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", {29'b0, rdy}, 32'd7);
        @(posedge clk); #1;

        // Unsigned maximum, latency 2 cycles after the last beat
        q0.push_back(32'd1040400);
        vec(0, 8'd255, 8'd255);
        chk("lat_cycle1", {31'b0, ov[0]}, 32'd0);
        @(posedge clk); #1;
        chk("lat_cycle2", {31'b0, ov[0]}, 32'd1);
        drain();

        // Signed extremes and a small negative result
        q1.push_back(32'd262144);
        vec(1, 8'h80, 8'h80);
        q1.push_back(32'hFFFD0);
        vec(1, 8'hFF, 8'h03);
        drain();

        // Back-to-back vectors, continuous in_valid
        waits = 0;
        q0.push_back(32'd40);
        q0.push_back(32'd104);
        for (int i = 1; i <= 8; i++) beat(0, 8'd1, 8'(i));
        chk("b2b_no_bubbles", 32'(waits), 32'd0);
        drain();

        // Backpressure: two vectors with out_ready low
        ordy[0] = 1'b0;
        q0.push_back(32'd16);
        q0.push_back(32'd32);
        vec(0, 8'd1, 8'd1);
        vec(0, 8'd2, 8'd1);
        chk("bp_in_ready_low", {31'b0, rdy[0]}, 32'd0);
        chk("bp_out_valid", {31'b0, ov[0]}, 32'd1);
        chk("bp_hold_a", {12'b0, o0}, 32'd16);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_b", {12'b0, o0}, 32'd16);
        chk("bp_still_stalled", {31'b0, rdy[0]}, 32'd0);
        ordy[0] = 1'b1;
        drain();

        // Flush after two beats; the beat offered during flush is dropped
        beat(0, 8'd1, 8'd1);
        beat(0, 8'd1, 8'd1);
        fl[0] = 1'b1; vin[0] = 1'b1;
        #1;
        chk("flush_in_ready", {31'b0, rdy[0]}, 32'd0);
        @(posedge clk); #1;
        fl[0] = 1'b0; vin[0] = 1'b0;
        chk("flush_beat_idx", {29'b0, b0}, 32'd0);
        q0.push_back(32'd16);
        vec(0, 8'd1, 8'd1);
        drain();

        // Reset mid-vector with a result pending
        ordy[0] = 1'b0;
        vec(0, 8'd1, 8'd1);
        beat(0, 8'd1, 8'd1);
        beat(0, 8'd1, 8'd1);
        chk("pre_rst_pending", {31'b0, ov[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, ov[0]}, 32'd0);
        chk("mid_rst_outp", {12'b0, o0}, 32'd0);
        chk("mid_rst_beat_idx", {29'b0, b0}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        q0.push_back(32'd16);
        vec(0, 8'd1, 8'd1);
        drain();

        // Narrow output: saturate or wrap depending on build
`ifdef DOT_PRODUCT_STREAM_SAT_EN
        q2.push_back(32'h8000FFFF);
`else
        q2.push_back(32'd57360);
`endif
        vec(2, 8'd255, 8'd255);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dot_product_stream.md
Name: dot_product_stream

Overview:
- Streaming, pipelined, multi-beat dot-product engine; successor to the single-shot combinational dot product.
- Accepts N lanes of operand pairs per beat over a valid/ready handshake.
- Accumulates over BEATS beats, so one vector is N*BEATS elements long, and emits one result per vector over a valid/ready output.
- Sits between operand buffers and downstream accumulation/activation logic; supports signed or unsigned operands.

Parameters:
- N, 4: lanes (element pairs) per beat, >=1.
- DW, 8: element width in bits.
- BEATS, 4: beats per vector, >=1.
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands and result.
- AW, 2*DW+$clog2(N*BEATS): internal accumulator width, lossless; for N*BEATS=1 use 2*DW.
- OW, AW: result width, <= AW.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the partial vector.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- inp1  in  DW*N  lane i at [(i+1)*DW-1 : i*DW].
- inp2  in  DW*N  same packing as inp1.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- outp  out  OW  dot product of the completed vector.
- beat_idx  out  $clog2(BEATS)+1  beats accepted in the current vector.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, outp=0, beat_idx=0, pipeline valids=0, accumulator=0. in_ready=1 from the first cycle after release. Reset mid-vector discards all partial state.
- Stage 1, on each accepted beat:
  - Register N lane products, each 2*DW wide (signed multiply if SIGNED=1).
  - Register p1_valid=1 and flags p1_first (beat_idx==0) and p1_last (beat_idx==BEATS-1).
  - beat_idx increments; it wraps to 0 after BEATS-1.
- Stage 2, when p1_valid and not stalled:
  - lane_sum = sum of the N products, sign-extended to AW when SIGNED=1.
  - acc <= (p1_first ? 0 : acc) + lane_sum.
  - If p1_last: outp <= final value reduced to OW (wrap, i.e. low OW bits) and out_valid <= 1.
- Output handshake:
  - out_valid clears on out_valid && out_ready unless a new result loads that same cycle; back-to-back results keep out_valid high.
  - outp is stable while out_valid && !out_ready.
- Stall:
  - stall = p1_valid && p1_last && out_valid && !out_ready.
  - in_ready = !stall. Stage 1 and stage 2 both hold while stalled.
  - No result is ever dropped or overwritten.
- Latency: last beat accepted in cycle t gives out_valid=1 in cycle t+2. Throughput is 1 beat/cycle with out_ready high.
- BEATS=1: every beat is both first and last.
- flush:
  - Clears beat_idx, p1_valid and acc.
  - in_ready=0 during the flush cycle; an in_valid beat that cycle is not accepted.
  - Does not touch a pending out_valid/outp.
  - A p1_last beat flushed before stage 2 produces no result.
- Arithmetic: no overflow is possible inside AW. Unsigned max = N*BEATS*(2^DW-1)^2. Signed extreme = N*BEATS*2^(2*DW-2).

Optional Feature:
- Macro DOT_PRODUCT_STREAM_SAT_EN.
- Defined: reduction from AW to OW saturates.
  - Unsigned: clamp to 2^OW-1.
  - Signed: clamp to [-2^(OW-1), 2^(OW-1)-1].
  - Adds output sat_flag (1 bit), registered alongside outp; 1 when the delivered result was clamped; reset 0.
- Undefined: low OW bits are kept (wrap) and sat_flag does not exist.
- With OW==AW both builds are identical apart from sat_flag, which stays 0.

Test Plan:
- Unsigned default, lanes all 255, 4 beats, out_ready=1 -> outp=1040400, out_valid rises 2 cycles after beat 4.
- SIGNED=1, lanes all -128 in both operands, 4 beats -> outp=262144. Then inp1=-1, inp2=3 on all lanes -> outp=-48 (0xFFFD0 in 20 bits).
- Back-to-back vectors with inp1 lanes=1, inp2 lanes=beat number (1,2,3,4 then 5,6,7,8), continuous in_valid -> outp=40 then 104, no bubbles, 8 consecutive in_ready=1.
- Backpressure: out_ready=0 while 2 vectors stream -> in_ready drops when the 2nd vector's last beat reaches stage 1; first outp held. Raising out_ready delivers both results in order, none lost.
- flush after 2 beats, then a full vector of 1*1 -> outp=16 and no partial result. Also rst_n=0 mid-vector -> all outputs 0 immediately.
- OW=16, unsigned, lanes all 255: with DOT_PRODUCT_STREAM_SAT_EN outp=65535 and sat_flag=1; without it outp=57360.
